calibration_sequencer: RTL and testbench

CALIBRATION_SEQUENCER -- requirements
Module: calibration_sequencer

---
 rtl/calibration_sequencer.sv | 142 ++++++++++++++
 tb/tb_calibration_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calibration_sequencer.sv
// Steps an LED-ID calibration run MSB first, one capture step per ID bit, and arbitrates the
// shared accumulator with the readout client. Define CALIBRATION_SEQUENCER_TIMEOUT_EN for the per-step watchdog.
module calibration_sequencer #(
    parameter int LED_ADDRESS_WIDTH = 10,
    parameter int STEP_TIMEOUT      = 50000000
) (
    input  logic                                 clk_pixel,
    input  logic                                 rst,
    input  logic                                 start_in,
    input  logic                                 abort_in,
    input  logic [2:0]                           step_state_in,
    output logic                                 step_trigger_out,
    output logic                                 should_overwrite_out,
    output logic [$clog2(LED_ADDRESS_WIDTH)-1:0] pattern_bit_out,
    input  logic                                 readout_req_in,
    output logic                                 read_request_out,
    output logic                                 readout_grant_out,
    output logic                                 busy_out,
    output logic                                 done_out,
    output logic                                 error_out
);

    localparam int BW = $clog2(LED_ADDRESS_WIDTH);
    localparam logic [BW-1:0] TOP_BIT = BW'(LED_ADDRESS_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_NEXT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   bit_idx_q, bit_idx_d;
    logic            start_q, start_d;
    logic            start_armed_q, start_armed_d;
    logic            start_rise;
    logic            timed_out;

    // A start held high across reset must fall once before it can launch a run.
    assign start_rise = start_in && !start_q && start_armed_q;

`ifdef CALIBRATION_SEQUENCER_TIMEOUT_EN
    localparam int CW = $clog2(STEP_TIMEOUT + 1);
    localparam logic [CW-1:0] TIMER_MAX  = CW'(STEP_TIMEOUT);
    localparam logic [CW-1:0] TIMER_LAST = CW'(STEP_TIMEOUT - 1);

    logic [CW-1:0] timer_q, timer_d, timer_inc;

    // Saturating so a long WAIT_BUSY cannot wrap past the limit.
    assign timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
    assign timed_out = (timer_inc >= TIMER_LAST);

    always_comb begin
        timer_d = timer_q;
        case (state_q)
            S_ISSUE:                  timer_d = '0;
            S_WAIT_BUSY, S_WAIT_DONE: timer_d = timer_inc;
            default:                  timer_d = timer_q;
        endcase
    end

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign error_out = (state_q == S_ERROR);
`else
    assign timed_out = 1'b0;
    assign error_out = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        bit_idx_d     = bit_idx_q;
        start_d       = start_in;
        start_armed_d = start_armed_q || !start_in;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_rise) begin
                    bit_idx_d = TOP_BIT;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE:     state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: if (step_state_in != 3'd0) state_d = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (step_state_in == 3'd0) begin
                    state_d = S_NEXT;
                end else if (timed_out) begin
                    state_d = S_ERROR;
                end
            end
            S_NEXT: begin
                if (bit_idx_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    bit_idx_d = bit_idx_q - 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            default:     state_d = S_IDLE;
        endcase
        if (abort_in) begin
            state_d   = S_IDLE;
            bit_idx_d = bit_idx_q;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            state_q       <= S_IDLE;
            bit_idx_q     <= '0;
            start_q       <= 1'b0;
            start_armed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_idx_q     <= bit_idx_d;
            start_q       <= start_d;
            start_armed_q <= start_armed_d;
        end
    end

    assign busy_out = (state_q == S_ISSUE) || (state_q == S_WAIT_BUSY) ||
                      (state_q == S_WAIT_DONE) || (state_q == S_NEXT);
    assign done_out = (state_q == S_DONE);

    // Gated so an abort or reset landing on ISSUE cannot leak a pulse.
    assign step_trigger_out     = (state_q == S_ISSUE) && !abort_in && !rst;
    assign should_overwrite_out = busy_out && (bit_idx_q == TOP_BIT);
    assign pattern_bit_out      = bit_idx_q;
    assign readout_grant_out    = !busy_out;
    assign read_request_out     = readout_req_in && readout_grant_out;

endmodule

// File: tb/tb_calibration_sequencer.sv
// Bench for calibration_sequencer: scenario table, randomized runs against a timing model, and reset/timeout sequences.
module tb_calibration_sequencer;

    localparam int W  = 3;
    localparam int TO = 20;
    localparam int BW = $clog2(W);

    logic          clk_pixel = 1'b0;
    logic          rst = 1'b1;
    logic          start_in = 1'b0;
    logic          abort_in = 1'b0;
    logic [2:0]    step_state_in = 3'd0;
    logic          readout_req_in = 1'b0;
    logic          step_trigger_out, should_overwrite_out, read_request_out;
    logic          readout_grant_out, busy_out, done_out, error_out;
    logic [BW-1:0] pattern_bit_out;

    calibration_sequencer #(.LED_ADDRESS_WIDTH(W), .STEP_TIMEOUT(TO)) dut (
        .clk_pixel(clk_pixel),
        .rst(rst),
        .start_in(start_in),
        .abort_in(abort_in),
        .step_state_in(step_state_in),
        .step_trigger_out(step_trigger_out),
        .should_overwrite_out(should_overwrite_out),
        .pattern_bit_out(pattern_bit_out),
        .readout_req_in(readout_req_in),
        .read_request_out(read_request_out),
        .readout_grant_out(readout_grant_out),
        .busy_out(busy_out),
        .done_out(done_out),
        .error_out(error_out)
    );

    always #5 clk_pixel = ~clk_pixel;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Step FSM model: registers the trigger, idles step_delay cycles, then is busy step_len cycles.
    int step_delay = 0;
    int step_len   = 5;
    int lead       = 0;
    int left       = 0;
    bit trig_prev  = 1'b0;
    bit stuck      = 1'b0;

    typedef struct {
        int delay;
        int len;
        int abort_step;
        bit req;
        bit restart;
        int exp_trig;
        bit exp_done;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pixel);
        #1;
        if (trig_prev) begin
            lead = step_delay;
            left = step_len;
        end
        if (stuck) begin
            step_state_in = 3'd2;
        end else if (left > 0) begin
            if (lead > 0) begin
                lead--;
                step_state_in = 3'd0;
            end else begin
                step_state_in = 3'(1 + (left % 7));
                left--;
            end
        end else begin
            step_state_in = 3'd0;
        end
        #1;
        cyc++;
        trig_prev = step_trigger_out;
    endtask

    // Timing model: every step lasts P = delay + len + 3 cycles from its trigger to the next
    // trigger (or DONE); an abort in WAIT_DONE of step ab ends the run the following cycle.
    task automatic run_scenario(input int d, input int len, input int ab, input bit req,
                                input bit restart, input bit rand_req,
                                output int ntrig, output bit done_seen);
        int t0, p, t_end, ca, last_busy, k, exp_bit;
        bit run;
        ntrig          = 0;
        done_seen      = 1'b0;
        step_delay     = d;
        step_len       = len;
        readout_req_in = req;
        start_in       = 1'b1;
        tick();
        start_in  = 1'b0;
        t0        = cyc;
        p         = d + len + 3;
        t_end     = t0 + W * p;
        ca        = (ab >= 0) ? t0 + ab * p + d + 2 : t_end + 100;
        last_busy = (ab >= 0) ? ca : t_end - 1;
        for (int c = t0; c <= t_end + 3; c++) begin
            run     = (c >= t0) && (c <= last_busy);
            k       = (c - t0) / p;
            exp_bit = run ? (W - 1 - k) : ((ab >= 0) ? (W - 1 - ab) : 0);
            check("trigger", step_trigger_out, run && ((c - t0) % p == 0));
            check("busy", busy_out, run);
            check("grant", readout_grant_out, !run);
            check("read_request", read_request_out, readout_req_in && !run);
            check("pattern_bit", pattern_bit_out, exp_bit);
            check("overwrite", should_overwrite_out, run && (k == 0));
            check("done", done_out, (ab < 0) && (c >= t_end));
            check("error", error_out, 0);
            if (step_trigger_out) ntrig++;
            if (done_out) done_seen = 1'b1;
            abort_in = (c == ca);
            start_in = restart && (c == t0 + 1);
            if (rand_req) readout_req_in = 1'($urandom);
            tick();
        end
        abort_in = 1'b0;
        start_in = 1'b0;
        repeat (d + len + 3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int nt, ab, dly, ln;
        bit ds;

        vecs[0] = '{0, 5, -1, 1'b1, 1'b0, 3, 1'b1};
        vecs[1] = '{0, 5,  1, 1'b1, 1'b0, 2, 1'b0};
        vecs[2] = '{1, 3, -1, 1'b0, 1'b1, 3, 1'b1};
        vecs[3] = '{2, 1, -1, 1'b1, 1'b1, 3, 1'b1};
        vecs[4] = '{0, 2,  0, 1'b0, 1'b0, 1, 1'b0};
        vecs[5] = '{3, 4,  2, 1'b1, 1'b0, 3, 1'b0};

        // Reset with start held high: reset values, and no run until start falls and rises.
        rst      = 1'b1;
        start_in = 1'b1;
        readout_req_in = 1'b1;
        tick();
        tick();
        check("rst_trigger", step_trigger_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_done", done_out, 0);
        check("rst_error", error_out, 0);
        check("rst_overwrite", should_overwrite_out, 0);
        check("rst_grant", readout_grant_out, 1);
        check("rst_pattern", pattern_bit_out, 0);
        check("rst_read_request", read_request_out, 1);
        rst = 1'b0;
        repeat (4) begin
            tick();
            check("held_start_busy", busy_out, 0);
            check("held_start_trigger", step_trigger_out, 0);
        end
        start_in = 1'b0;
        readout_req_in = 1'b0;
        tick();
        check("idle_busy", busy_out, 0);

        for (int i = 0; i < 6; i++) begin
            run_scenario(vecs[i].delay, vecs[i].len, vecs[i].abort_step, vecs[i].req,
                         vecs[i].restart, 1'b0, nt, ds);
            check("vec_trigger_count", nt, vecs[i].exp_trig);
            check("vec_done_seen", ds, vecs[i].exp_done);
            $display("vector %0d: delay=%0d len=%0d abort=%0d triggers=%0d done=%0d",
                     i, vecs[i].delay, vecs[i].len, vecs[i].abort_step, nt, ds);
        end

        for (int i = 0; i < 12; i++) begin
            dly = $urandom_range(0, 3);
            ln  = $urandom_range(1, 6);
            ab  = int'($urandom_range(0, W)) - 1;
            run_scenario(dly, ln, ab, 1'b0, 1'($urandom), 1'b1, nt, ds);
            check("rand_trigger_count", nt, (ab < 0) ? W : ab + 1);
            check("rand_done_seen", ds, ab < 0);
            $display("random %0d: delay=%0d len=%0d abort=%0d triggers=%0d done=%0d",
                     i, dly, ln, ab, nt, ds);
        end

        // Reset mid-run while waiting for the step to go busy.
        step_delay = 2;
        step_len   = 5;
        start_in   = 1'b1;
        tick();
        start_in = 1'b0;
        check("midrst_first_trigger", step_trigger_out, 1);
        tick();
        check("midrst_wait_busy", busy_out, 1);
        rst      = 1'b1;
        start_in = 1'b1;
        tick();
        check("midrst_trigger", step_trigger_out, 0);
        check("midrst_busy", busy_out, 0);
        check("midrst_done", done_out, 0);
        check("midrst_overwrite", should_overwrite_out, 0);
        check("midrst_grant", readout_grant_out, 1);
        check("midrst_pattern", pattern_bit_out, 0);
        tick();
        rst = 1'b0;
        repeat (4) begin
            tick();
            check("midrst_held_trigger", step_trigger_out, 0);
            check("midrst_held_busy", busy_out, 0);
        end
        start_in = 1'b0;
        tick();
        start_in = 1'b1;
        tick();
        check("midrst_relaunch_trigger", step_trigger_out, 1);
        check("midrst_relaunch_pattern", pattern_bit_out, W - 1);
        start_in = 1'b0;
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        check("midrst_abort_busy", busy_out, 0);
        repeat (12) tick();
        $display("mid-run reset sequence complete at cycle %0d", cyc);

        // Step FSM stuck non-idle after the trigger.
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        check("stuck_trigger", step_trigger_out, 1);
        stuck = 1'b1;
        for (int k = 1; k <= TO; k++) begin
            tick();
            if (k == TO - 1) check("stuck_error_early", error_out, 0);
        end
`ifdef CALIBRATION_SEQUENCER_TIMEOUT_EN
        check("timeout_error", error_out, 1);
        check("timeout_busy", busy_out, 0);
        check("timeout_done", done_out, 0);
        stuck = 1'b0;
        left  = 0;
        tick();
        check("error_held", error_out, 1);
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        check("restart_trigger", step_trigger_out, 1);
        check("restart_pattern", pattern_bit_out, W - 1);
        check("restart_overwrite", should_overwrite_out, 1);
        check("restart_error_cleared", error_out, 0);
`else
        check("no_timeout_error", error_out, 0);
        check("no_timeout_busy", busy_out, 1);
        stuck = 1'b0;
        left  = 0;
`endif
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        check("stuck_abort_busy", busy_out, 0);
        check("stuck_abort_error", error_out, 0);
        $display("stuck-step sequence complete at cycle %0d", cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
